// File: rtl/rs_cmd_pkg.sv
// rs_cmd_pkg
//   Shared definitions for the RS flip-flop command generator:
//   - state_t : FSM state encoding (IDLE, DRIVE_S, DRIVE_R, GAP)
//   - pend_t  : one-deep pending-slot / command codes (NONE, SET, CLR)
//   - next_cmd: picks the command to launch from this cycle's events and
//               the pending slot (a fresh event beats the stored one).
package rs_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE_S = 2'd1,
    DRIVE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SET  = 2'd1,
    CLR  = 2'd2
  } pend_t;

  // Set and clear events are already mutually exclusive here; a
  // simultaneous pair is filtered out as a conflict before this point.
  function automatic pend_t next_cmd(input logic set_ev,
                                     input logic clr_ev,
                                     input pend_t pend);
    if (set_ev)      return SET;
    else if (clr_ev) return CLR;
    else             return pend;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync
//   Two-flop synchronizer followed by a level debouncer for one raw
//   asynchronous request line.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset
//   din   : raw asynchronous level
//   level : debounced level
//   rise  : one-cycle pulse, registered together with a 0->1 level flip
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The flip happens on the edge where the count would reach
  // DEBOUNCE_CYCLES, so the stored count never exceeds DEBOUNCE_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others (the sync chain relies on it).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 == r_level) begin
        // Any agreeing sample restarts the qualification window.
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= ~r_level;
        r_rise  <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/rs_cmd_gen.sv
// rs_cmd_gen
//   Turns two raw asynchronous request lines into clean, fixed-width S/R
//   pulses for an RS flip-flop. Each pulse lasts PULSE_CYCLES cycles and is
//   followed by one hold cycle (S=R=0). S and R are never high together.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   set_req  : raw asynchronous set request (level)
//   clr_req  : raw asynchronous clear request (level)
//   S        : set pulse to the flip-flop
//   R        : reset pulse to the flip-flop
//   busy     : high from the first drive cycle through the gap cycle
//   conflict : one-cycle flag, set and clear events arrived together
import rs_cmd_pkg::*;

module rs_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYCLES - 1);

  logic    w_set_level;
  logic    w_set_rise;
  logic    w_clr_level;
  logic    w_clr_rise;
  logic    w_set_ev;
  logic    w_clr_ev;
  logic    w_conflict;
  pend_t   w_cmd;

  state_t  r_state;
  pend_t   r_pend;
  logic [PW-1:0] r_pcnt;
  logic    r_s;
  logic    r_r;
  logic    r_busy;
  logic    r_conflict;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk   (clk),
    .rst   (rst),
    .din   (set_req),
    .level (w_set_level),
    .rise  (w_set_rise)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk   (clk),
    .rst   (rst),
    .din   (clr_req),
    .level (w_clr_level),
    .rise  (w_clr_rise)
  );

  // A rise pulse always coincides with the level being high; qualifying
  // with the level keeps the event definition explicit.
  assign w_set_ev   = w_set_rise & w_set_level & ~(w_clr_rise & w_clr_level);
  assign w_clr_ev   = w_clr_rise & w_clr_level & ~(w_set_rise & w_set_level);
  assign w_conflict = w_set_rise & w_set_level & w_clr_rise & w_clr_level;

  // NOTE: combinational logic gets a full assignment on every path so no
  // latch is inferred; next_cmd returns a value in every branch.
  always_comb begin
    w_cmd = next_cmd(w_set_ev, w_clr_ev, r_pend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= NONE;
      r_pcnt     <= '0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_conflict;
      case (r_state)
        // The gap cycle may launch the next command directly, so commands
        // can be spaced PULSE_CYCLES+1 cycles apart.
        IDLE, GAP: begin
          r_pcnt <= '0;
          r_s    <= 1'b0;
          r_r    <= 1'b0;
          if (w_cmd == SET) begin
            r_state <= DRIVE_S;
            r_s     <= 1'b1;
            r_busy  <= 1'b1;
            r_pend  <= NONE;
          end else if (w_cmd == CLR) begin
            r_state <= DRIVE_R;
            r_r     <= 1'b1;
            r_busy  <= 1'b1;
            r_pend  <= NONE;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        DRIVE_S, DRIVE_R: begin
          // Last single event wins; a conflicting pair leaves the slot alone.
          if (w_set_ev)      r_pend <= SET;
          else if (w_clr_ev) r_pend <= CLR;
          if (r_pcnt == P_LAST) begin
            r_state <= GAP;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt + PW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign busy     = r_busy;
  assign conflict = r_conflict;

endmodule
